mul_16bit: RTL and testbench

- Multi-cycle reconstruction multiplier: the inverse of the team's 16-by-8 divider.
- Takes quotient Q (16 bit), divisor B (8 bit) and remainder R (8 bit), and computes A = Q*B + R as a 24-bit result.
- Used to rebuild dividends and to cross-check divider output in the arithmetic datapath.
- Radix-2 shift-add, one multiplier bit per clock, start/ready/done handshake.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_16bit.sv | 107 ++++++++++
 tb/tb_mul_16bit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and default widths for the shift-add reconstruction multiplier.
package mul_pkg;

   localparam int MUL_QW = 16;
   localparam int MUL_BW = 8;
   localparam int CNT_W  = $clog2(MUL_BW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul_16bit.sv
// Radix-2 shift-add multiplier computing product = Q*B + R, one bit of B per clock.
// state | meaning
// IDLE  | ready=1, waiting for start; product/rem_err hold the last result
// RUN   | BW shift-add steps, one per clock
// DONE  | one-cycle done pulse, product valid
module mul_16bit
   import mul_pkg::*;
#(
   parameter int QW = MUL_QW,
   parameter int BW = MUL_BW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [QW-1:0]   Q,
   input  logic [BW-1:0]   B,
   input  logic [BW-1:0]   R,
   output logic            ready,
   output logic            done,
   output logic [QW+BW-1:0] product,
   output logic            rem_err
);

   localparam int PW = QW + BW;
   localparam int CW = (BW == MUL_BW) ? CNT_W : $clog2(BW);

   state_e          state_q, state_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   mq_q, mq_d;
   logic [BW-1:0]   mb_q, mb_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rem_pend_q, rem_pend_d;
   logic [PW-1:0]   product_q, product_d;
   logic            rem_err_q, rem_err_d;
   logic [PW-1:0]   step_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         mq_q       <= '0;
         mb_q       <= '0;
         cnt_q      <= '0;
         rem_pend_q <= 1'b0;
         product_q  <= '0;
         rem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mq_q       <= mq_d;
         mb_q       <= mb_d;
         cnt_q      <= cnt_d;
         rem_pend_q <= rem_pend_d;
         product_q  <= product_d;
         rem_err_q  <= rem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mq_d       = mq_q;
      mb_d       = mb_q;
      cnt_d      = cnt_q;
      rem_pend_d = rem_pend_q;
      product_d  = product_q;
      rem_err_d  = rem_err_q;
      ready      = 1'b0;
      done       = 1'b0;
      step_sum   = mb_q[0] ? (acc_q + mq_q) : acc_q;

      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               mq_d       = PW'(Q);
               mb_d       = B;
               acc_d      = PW'(R);
               cnt_d      = '0;
               rem_pend_d = (R >= B);
               state_d    = RUN;
            end
         end
         RUN: begin
            acc_d = step_sum;
            mq_d  = mq_q << 1;
            mb_d  = mb_q >> 1;
            cnt_d = cnt_q + CW'(1);
            // Result registers update only here, so they stay stable through IDLE.
            if (cnt_q == CW'(BW - 1)) begin
               product_d = step_sum;
               rem_err_d = rem_pend_q;
               state_d   = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign product = product_q;
   assign rem_err = rem_err_q;

endmodule

// File: tb/tb_mul_16bit.sv
// Self-checking bench for mul_16bit: directed vector table, handshake corner cases,
// reset abort and random operations checked against Q*B+R through a scoreboard.
module tb_mul_16bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] Q;
   logic [7:0]  B;
   logic [7:0]  R;
   logic        ready;
   logic        done;
   logic [23:0] product;
   logic        rem_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [23:0] p;
      logic        e;
   } exp_t;

   typedef struct packed {
      logic [15:0] q;
      logic [7:0]  b;
      logic [7:0]  r;
      logic [23:0] p;
      logic        e;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[8];
   logic [23:0] prev_p;
   logic        prev_e;

   mul_16bit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .Q       (Q),
      .B       (B),
      .R       (R),
      .ready   (ready),
      .done    (done),
      .product (product),
      .rem_err (rem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t x;
      if (rst === 1'b0 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done product %h", product);
         end else begin
            x = sb_q.pop_front();
            check("sb_product", 32'(product), 32'(x.p));
            check("sb_rem_err", 32'(rem_err), 32'(x.e));
         end
      end
   end

   // Called at a negedge; returns at the negedge where ready is back (sample 10).
   task automatic run_op(input logic [15:0] q, input logic [7:0] b, input logic [7:0] r,
                         input logic [23:0] ep, input logic ee, input bit noisy, input bit hold);
      int   w;
      bit   ok;
      exp_t x;
      w = 0;
      while (ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout ready %b want 1", ready);
         return;
      end
      Q = q; B = b; R = r; start = 1'b1;
      x.p = ep; x.e = ee;
      sb_q.push_back(x);
      ok = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         Q = 16'($urandom); B = 8'($urandom); R = 8'($urandom);
         start = hold | (noisy && (k == 3 || k == 6));
         if (ready !== 1'b0 || done !== 1'b0 || product !== prev_p || rem_err !== prev_e)
            ok = 1'b0;
      end
      check("run_phase_ok", 32'(ok), 32'd1);
      @(negedge clk);
      start = hold | noisy;
      check("done_at_9", 32'({ready, done}), 32'b01);
      check("product_at_done", 32'(product), 32'(ep));
      @(negedge clk);
      start = hold;
      check("ready_at_10", 32'({ready, done}), 32'b10);
      check("held_product", 32'(product), 32'(ep));
      check("held_rem_err", 32'(rem_err), 32'(ee));
      prev_p = ep;
      prev_e = ee;
   endtask

   initial begin
      logic [15:0] q;
      logic [7:0]  b;
      logic [7:0]  r;
      bit          ok;

      vecs[0] = '{16'h1234, 8'h05, 8'h03, 24'h005B07, 1'b0};
      vecs[1] = '{16'hFFFF, 8'hFF, 8'hFE, 24'hFEFFFF, 1'b0};
      vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 24'hFF0000, 1'b1};
      vecs[3] = '{16'hABCD, 8'h00, 8'h07, 24'h000007, 1'b1};
      vecs[4] = '{16'h0000, 8'h09, 8'h02, 24'h000002, 1'b0};
      vecs[5] = '{16'h00FF, 8'h02, 8'h02, 24'h000200, 1'b1};
      vecs[6] = '{16'h8000, 8'h80, 8'h7F, 24'h40007F, 1'b0};
      vecs[7] = '{16'h0001, 8'h01, 8'h00, 24'h000001, 1'b0};

      rst = 1'b1; start = 1'b0; Q = '0; B = '0; R = '0;
      prev_p = '0; prev_e = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_rem_err", 32'(rem_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].p, vecs[i].e, (i % 2) == 1, 1'b0);

      // start held high: back-to-back operations with no idle gap beyond the single IDLE cycle
      for (int i = 0; i < 3; i++) begin
         q = 16'($urandom); b = 8'($urandom); r = 8'($urandom);
         run_op(q, b, r, 24'(q) * 24'(b) + 24'(r), r >= b, 1'b0, 1'b1);
      end
      start = 1'b0;
      @(negedge clk);

      // abort mid-run: asynchronous reset must clear outputs before the next clock edge
      Q = 16'h0F0F; B = 8'h33; R = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      check("abort_rem_err", 32'(rem_err), 32'd0);
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || ready !== 1'b1) ok = 1'b0;
      end
      check("abort_no_done", 32'(ok), 32'd1);
      prev_p = '0; prev_e = 1'b0;
      run_op(16'h0102, 8'h03, 8'h02, 24'h000308, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         q = 16'($urandom);
         b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         r = 8'($urandom);
         run_op(q, b, r, 24'(q) * 24'(b) + 24'(r), r >= b, ($urandom_range(0, 3) == 0), 1'b0);
      end

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
